// File: rtl/bdpsk_pkg.sv
// Shared BDPSK definitions used by both the encoder and the decoder:
// symbol geometry, sample coding, FSM state encoding and datapath types.
package bdpsk_pkg;

  localparam int SAMPLES_PER_SYM = 128;
  localparam int SAMPLE_W        = 8;
  localparam int MIDPOINT        = 127;
  localparam int ACC_W           = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } bdpsk_state_e;

  // Centred sample: SAMPLE_W+1 bits signed, range -MIDPOINT..(2^SAMPLE_W-1-MIDPOINT)
  typedef logic signed [SAMPLE_W:0] csample_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/bdpsk_delay_line.sv
// One-symbol circular delay line for centred samples. The entry under the
// write pointer is presented combinationally (the sample from one symbol
// earlier) and replaced by the new sample on the same accepting edge.
// Only the pointer is cleared by reset; the storage is never initialised.
module bdpsk_delay_line #(
  parameter int DEPTH = bdpsk_pkg::SAMPLES_PER_SYM,
  parameter int WIDTH = bdpsk_pkg::SAMPLE_W + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic signed [WIDTH-1:0] wr_data,
  output logic signed [WIDTH-1:0] rd_data
);
  import bdpsk_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic signed [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]        ptr_q;
  logic [PTR_W-1:0]        ptr_d;

  assign rd_data = mem_q[ptr_q];

  // Pointer advances once per write and wraps naturally (DEPTH is a power of two)
  always_comb begin
    ptr_d = ptr_q;
    if (wr_en) ptr_d = ptr_q + PTR_W'(1);
  end

  // Pointer register with synchronous clear
  always_ff @(posedge clk) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  // Storage write after the old entry has been read out
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[ptr_q] <= wr_data;
  end

endmodule

// File: rtl/bdpsk_decoder.sv
// BDPSK demodulator: centres each sample, multiplies it with the sample one
// symbol earlier, integrates over the symbol and slices on the sign of the
// integral (negative = phase reversal = bit 1).
// Optional feature macro: BDPSK_DEC_METRIC_EN adds the metric/weak outputs
// and the WEAK_THRESH parameter.
module bdpsk_decoder #(
  parameter int SAMPLES_PER_SYM = bdpsk_pkg::SAMPLES_PER_SYM,
  parameter int SAMPLE_W        = bdpsk_pkg::SAMPLE_W,
  parameter int MIDPOINT        = bdpsk_pkg::MIDPOINT,
  parameter int ACC_W           = bdpsk_pkg::ACC_W
`ifdef BDPSK_DEC_METRIC_EN
  , parameter int WEAK_THRESH   = 65536
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_valid,
  input  logic [SAMPLE_W-1:0]     sample,
  input  logic                    sym_start,
  output logic                    bit_valid,
  output logic                    bit_out,
  output logic                    locked
`ifdef BDPSK_DEC_METRIC_EN
  , output logic signed [ACC_W-1:0] metric
  , output logic                    weak
`endif
);
  import bdpsk_pkg::*;

  localparam int                     CW    = SAMPLE_W + 1;
  localparam int                     PW    = 2 * CW;
  localparam int                     CNT_W = $clog2(SAMPLES_PER_SYM);
  localparam logic [CNT_W-1:0]       LAST  = CNT_W'(SAMPLES_PER_SYM - 1);
  localparam logic signed [CW-1:0]   MID_C = CW'(MIDPOINT);

  bdpsk_state_e            state_q, state_d;
  logic [CNT_W-1:0]        sym_cnt_q, sym_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    bit_valid_q, bit_valid_d;
  logic                    bit_out_q, bit_out_d;
  logic                    locked_q, locked_d;
  logic                    wr_en;

  logic signed [CW-1:0]    c_p0;
  logic signed [CW-1:0]    d_p0;
  logic signed [PW-1:0]    prod_p0;
  logic signed [ACC_W-1:0] acc_sum_p0;

`ifdef BDPSK_DEC_METRIC_EN
  logic signed [ACC_W-1:0] metric_q, metric_d;
  logic                    weak_q, weak_d;

  // Magnitude compare done one bit wider so the most negative value cannot overflow
  function automatic logic is_weak(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] mag;
    mag = a[ACC_W-1] ? -((ACC_W+1)'(a)) : (ACC_W+1)'(a);
    return mag < (ACC_W+1)'(WEAK_THRESH);
  endfunction
`endif

  // ---- p0: centre, delay, multiply, integrate (all combinational) ----
  assign c_p0       = $signed({1'b0, sample}) - MID_C;
  assign prod_p0    = PW'(c_p0) * PW'(d_p0);
  assign acc_sum_p0 = acc_q + ACC_W'(prod_p0);

  bdpsk_delay_line #(
    .DEPTH (SAMPLES_PER_SYM),
    .WIDTH (CW)
  ) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en && reset_n),
    .wr_data (c_p0),
    .rd_data (d_p0)
  );

  // Next-state, symbol timing, accumulation and bit decision
  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    acc_d       = acc_q;
    bit_valid_d = 1'b0;
    bit_out_d   = bit_out_q;
    locked_d    = locked_q;
    wr_en       = 1'b0;
`ifdef BDPSK_DEC_METRIC_EN
    metric_d    = metric_q;
    weak_d      = weak_q;
`endif
    if (sample_valid) begin
      case (state_q)
        IDLE: begin
          if (sym_start) begin
            wr_en     = 1'b1;
            sym_cnt_d = CNT_W'(1);
            acc_d     = '0;
            state_d   = PRIME;
          end
        end
        PRIME, RUN: begin
          wr_en = 1'b1;
          if (sym_start && (sym_cnt_q != '0)) begin
            // Misaligned symbol start: drop the partial symbol and re-prime
            sym_cnt_d = CNT_W'(1);
            acc_d     = '0;
            state_d   = PRIME;
            locked_d  = 1'b0;
          end else begin
            sym_cnt_d = sym_cnt_q + CNT_W'(1);
            if (state_q == PRIME) begin
              if (sym_cnt_q == LAST) begin
                state_d  = RUN;
                locked_d = 1'b1;
                acc_d    = '0;
              end
            end else if (sym_cnt_q == LAST) begin
              bit_valid_d = 1'b1;
              bit_out_d   = acc_sum_p0[ACC_W-1];
              acc_d       = '0;
`ifdef BDPSK_DEC_METRIC_EN
              metric_d    = acc_sum_p0;
              weak_d      = is_weak(acc_sum_p0);
`endif
            end else begin
              acc_d = acc_sum_p0;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // ---- p1: registered state and decision outputs ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sym_cnt_q   <= '0;
      acc_q       <= '0;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      locked_q    <= 1'b0;
`ifdef BDPSK_DEC_METRIC_EN
      metric_q    <= '0;
      weak_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      acc_q       <= acc_d;
      bit_valid_q <= bit_valid_d;
      bit_out_q   <= bit_out_d;
      locked_q    <= locked_d;
`ifdef BDPSK_DEC_METRIC_EN
      metric_q    <= metric_d;
      weak_q      <= weak_d;
`endif
    end
  end

  assign bit_valid = bit_valid_q;
  assign bit_out   = bit_out_q;
  assign locked    = locked_q;
`ifdef BDPSK_DEC_METRIC_EN
  assign metric    = metric_q;
  assign weak      = weak_q;
`endif

endmodule
